// File: rtl/fwd_scoreboard_unit.sv
// Purpose: forwarding-select and load-use hazard unit with a shadow tag pipeline for EX and the post-EX stages.
// Latency: fwd_sel is decoded from registered state only; stall is combinational from ID decode plus registered state.
// Backpressure: hold freezes every register, including the stall counter; stall asks ID to hold and puts a bubble into EX.
//
// Ports:
//   i_clk, i_reset            : clock and synchronous active-high reset
//   i_hold                    : global pipeline freeze
//   i_flush                   : kill the ID-stage instruction
//   i_id_valid .. i_id_memread: ID-stage decode (sources, use mask, dest, regwrite, load)
//   o_stall                   : load-use stall request for PC and IF/ID
//   o_fwd_sel                 : per EX operand, 0 = register file, k = forward from post-EX stage k
//   o_stall_count             : saturating count of stalled cycles
module fwd_scoreboard_unit #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_hold,
    input  logic                        i_flush,
    input  logic                        i_id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   i_id_rs,
    input  logic [NUM_SRC-1:0]          i_id_use,
    input  logic [REG_AW-1:0]           i_id_rd,
    input  logic                        i_id_regwrite,
    input  logic                        i_id_memread,
    output logic                        o_stall,
    output logic [NUM_SRC*SEL_W-1:0]    o_fwd_sel,
    output logic [CNT_W-1:0]            o_stall_count
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
    } tag_t;

    // EX slot: destination tag plus the operands it reads.
    tag_t                       r_ex_tag;
    logic [NUM_SRC*REG_AW-1:0]  r_ex_rs;
    logic [NUM_SRC-1:0]         r_ex_use;

    // Post-EX tag pipe; index k is the stage that forwards with select k.
    tag_t                       r_pipe [1:FWD_STAGES];

    logic [CNT_W-1:0]           r_stall_count;
    logic [NUM_SRC-1:0]         w_haz;

    // Register 0 is hard-wired, so a write to it never produces a value.
    function automatic logic is_prod(input tag_t t, input logic [REG_AW-1:0] r);
        return t.v && t.wr && (t.rd != '0) && (t.rd == r);
    endfunction

    // Scan oldest to youngest so the youngest matching stage is the last write.
    always_comb begin
        o_fwd_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (r_ex_tag.v && r_ex_use[s] &&
                    is_prod(r_pipe[k], r_ex_rs[s*REG_AW +: REG_AW])) begin
                    o_fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    // A source is hazardous only if its youngest producer is a load that
    // will not yet have reached a forwarding stage when ID moves into EX.
    // Position j=0 is the EX slot, j>=1 is r_pipe[j]; the load is usable
    // once j >= LOAD_LAT, so an older load behind a younger ALU write of the
    // same register is shadowed and harmless.
    always_comb begin
        w_haz = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (i_id_use[s] && (i_id_rs[s*REG_AW +: REG_AW] != '0)) begin
                for (int k = FWD_STAGES; k >= 1; k--) begin
                    if (is_prod(r_pipe[k], i_id_rs[s*REG_AW +: REG_AW])) begin
                        w_haz[s] = r_pipe[k].ld && (k < LOAD_LAT);
                    end
                end
                if (is_prod(r_ex_tag, i_id_rs[s*REG_AW +: REG_AW])) begin
                    w_haz[s] = r_ex_tag.ld && (LOAD_LAT > 0);
                end
            end
        end
    end

    // Flush kills the ID instruction, so it also suppresses the stall.
    assign o_stall       = i_id_valid && !i_flush && (|w_haz);
    assign o_stall_count = r_stall_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ex_tag      <= '0;
            r_ex_rs       <= '0;
            r_ex_use      <= '0;
            for (int k = 1; k <= FWD_STAGES; k++) begin
                r_pipe[k] <= '0;
            end
            r_stall_count <= '0;
        end else if (!i_hold) begin
            for (int k = FWD_STAGES; k >= 2; k--) begin
                r_pipe[k] <= r_pipe[k-1];
            end
            r_pipe[1] <= r_ex_tag;

            if (i_flush || o_stall) begin
                r_ex_tag <= '0;
                r_ex_rs  <= '0;
                r_ex_use <= '0;
            end else begin
                r_ex_tag.v  <= i_id_valid;
                r_ex_tag.rd <= i_id_rd;
                r_ex_tag.wr <= i_id_regwrite;
                r_ex_tag.ld <= i_id_memread;
                r_ex_rs     <= i_id_rs;
                r_ex_use    <= i_id_use;
            end

            if (o_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Purpose: scoreboard bench for fwd_scoreboard_unit in a default and a deep (3 stages, load latency 2, 3-bit counter) build.
// Latency: stimulus driven at the falling edge, expectations for that cycle popped and compared 2 time units later.
// Backpressure: none on the bench side; hold, flush and reset are driven as part of the stimulus.
module tb_fwd_scoreboard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default build
    logic        d_reset = 1'b1, d_hold = 1'b0, d_flush = 1'b0, d_valid = 1'b0;
    logic [9:0]  d_rs = '0;
    logic [1:0]  d_use = '0;
    logic [4:0]  d_rd = '0;
    logic        d_wr = 1'b0, d_ld = 1'b0;
    logic        d_stall;
    logic [3:0]  d_sel;
    logic [15:0] d_cnt;

    // Deep build
    logic        e_reset = 1'b1, e_hold = 1'b0, e_flush = 1'b0, e_valid = 1'b0;
    logic [9:0]  e_rs = '0;
    logic [1:0]  e_use = '0;
    logic [4:0]  e_rd = '0;
    logic        e_wr = 1'b0, e_ld = 1'b0;
    logic        e_stall;
    logic [3:0]  e_sel;
    logic [2:0]  e_cnt;

    fwd_scoreboard_unit u_def (
        .i_clk(clk), .i_reset(d_reset), .i_hold(d_hold), .i_flush(d_flush),
        .i_id_valid(d_valid), .i_id_rs(d_rs), .i_id_use(d_use), .i_id_rd(d_rd),
        .i_id_regwrite(d_wr), .i_id_memread(d_ld),
        .o_stall(d_stall), .o_fwd_sel(d_sel), .o_stall_count(d_cnt)
    );

    fwd_scoreboard_unit #(.FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(3)) u_deep (
        .i_clk(clk), .i_reset(e_reset), .i_hold(e_hold), .i_flush(e_flush),
        .i_id_valid(e_valid), .i_id_rs(e_rs), .i_id_use(e_use), .i_id_rd(e_rd),
        .i_id_regwrite(e_wr), .i_id_memread(e_ld),
        .o_stall(e_stall), .o_fwd_sel(e_sel), .o_stall_count(e_cnt)
    );

    typedef struct {
        int   dut;
        int   n;
        logic stall;
        int   s0;
        int   s1;
        int   cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One ID cycle on the selected build plus the outputs expected during it.
    task automatic cyc(input int dut, input logic rst, input logic fl, input logic hd,
                       input logic v, input int rd, input int rs0, input int rs1,
                       input logic wr, input logic ld,
                       input logic es, input int e0, input int e1, input int ec);
        @(negedge clk);
        if (dut == 0) begin
            d_reset = rst; d_flush = fl; d_hold = hd; d_valid = v;
            d_rs = {5'(rs1), 5'(rs0)}; d_use = v ? 2'b11 : 2'b00;
            d_rd = 5'(rd); d_wr = wr; d_ld = ld;
        end else begin
            e_reset = rst; e_flush = fl; e_hold = hd; e_valid = v;
            e_rs = {5'(rs1), 5'(rs0)}; e_use = v ? 2'b11 : 2'b00;
            e_rd = 5'(rd); e_wr = wr; e_ld = ld;
        end
        #1;
        n_cyc++;
        sb.push_back('{dut, n_cyc, es, e0, e1, ec});
    endtask

    task automatic alu(input int dut, input int rd, input int rs0, input int rs1,
                       input logic es, input int e0, input int e1, input int ec);
        cyc(dut, 1'b0, 1'b0, 1'b0, 1'b1, rd, rs0, rs1, 1'b1, 1'b0, es, e0, e1, ec);
    endtask

    task automatic lw(input int dut, input int rd, input int base,
                      input logic es, input int e0, input int e1, input int ec);
        cyc(dut, 1'b0, 1'b0, 1'b0, 1'b1, rd, base, 0, 1'b1, 1'b1, es, e0, e1, ec);
    endtask

    task automatic nop(input int dut, input logic es, input int e0, input int e1, input int ec);
        cyc(dut, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, es, e0, e1, ec);
    endtask

    // Monitor: pops every expectation pushed this cycle and compares.
    always @(negedge clk) begin
        exp_t       e;
        logic       st;
        logic [1:0] s0, s1;
        int         c;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                st = d_stall; s0 = d_sel[1:0]; s1 = d_sel[3:2]; c = int'(d_cnt);
            end else begin
                st = e_stall; s0 = e_sel[1:0]; s1 = e_sel[3:2]; c = int'(e_cnt);
            end
            chk($sformatf("d%0d.c%0d.stall", e.dut, e.n), 32'(st), 32'(e.stall));
            chk($sformatf("d%0d.c%0d.sel0",  e.dut, e.n), 32'(s0), 32'(e.s0));
            chk($sformatf("d%0d.c%0d.sel1",  e.dut, e.n), 32'(s1), 32'(e.s1));
            chk($sformatf("d%0d.c%0d.count", e.dut, e.n), 32'(c),  32'(e.cnt));
            // A load may never be forwarded from a stage it has not yet passed.
            if (e.dut == 0 && (s0 == 2'd1 || s1 == 2'd1))
                chk($sformatf("d0.c%0d.inv1", e.n), 32'(u_def.r_pipe[1].ld), 32'd0);
            if (e.dut == 1 && (s0 == 2'd1 || s1 == 2'd1))
                chk($sformatf("d1.c%0d.inv1", e.n), 32'(u_deep.r_pipe[1].ld), 32'd0);
            if (e.dut == 1 && (s0 == 2'd2 || s1 == 2'd2))
                chk($sformatf("d1.c%0d.inv2", e.n), 32'(u_deep.r_pipe[2].ld), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // ---------------- default build: 2 stages, load latency 1 ----------------
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Back-to-back ALU forwarding: stage 1, then stage 2 for a later reader.
        alu(0, 3, 1, 2,   1'b0, 0, 0, 0);   // add $3,$1,$2
        alu(0, 5, 3, 4,   1'b0, 0, 0, 0);   // sub $5,$3,$4
        alu(0, 13, 3, 0,  1'b0, 1, 0, 0);   // sub in EX: $3 from stage 1
        nop(0,            1'b0, 2, 0, 0);   // reader in EX: $3 from stage 2, $0 never forwards

        // Youngest producer wins; writes to $0 never forward.
        alu(0, 3, 1, 1,   1'b0, 0, 0, 0);
        alu(0, 3, 2, 2,   1'b0, 0, 0, 0);
        alu(0, 14, 3, 0,  1'b0, 0, 0, 0);
        alu(0, 0, 5, 5,   1'b0, 1, 0, 0);   // reader sees $3 in stage 1 and 2 -> 1
        alu(0, 16, 0, 0,  1'b0, 0, 0, 0);
        nop(0,            1'b0, 0, 0, 0);   // $0 reader with $0 writer in stage 1 -> 0
        nop(0,            1'b0, 0, 0, 0);

        // Load-use: one stall cycle, bubble, then forward from stage 2.
        lw(0, 2, 1,       1'b0, 0, 0, 0);
        alu(0, 6, 2, 7,   1'b1, 0, 0, 0);
        alu(0, 6, 2, 7,   1'b0, 0, 0, 1);
        nop(0,            1'b0, 2, 0, 1);

        // Flush beats stall: no stall, no count, bubble in EX.
        lw(0, 2, 1,       1'b0, 0, 0, 1);
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b1, 6, 2, 7, 1'b1, 1'b0, 1'b0, 0, 0, 1);
        nop(0,            1'b0, 0, 0, 1);

        // Hold during a stall for 4 cycles: state and count frozen.
        lw(0, 2, 1,       1'b0, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            cyc(0, 1'b0, 1'b0, 1'b1, 1'b1, 6, 2, 7, 1'b1, 1'b0, 1'b1, 0, 0, 1);
        alu(0, 6, 2, 7,   1'b1, 0, 0, 1);
        alu(0, 6, 2, 7,   1'b0, 0, 0, 2);
        nop(0,            1'b0, 2, 0, 2);

        // Older load shadowed by a younger ALU write of the same register.
        lw(0, 2, 1,       1'b0, 0, 0, 2);
        alu(0, 2, 1, 1,   1'b0, 0, 0, 2);
        alu(0, 17, 2, 0,  1'b0, 0, 0, 2);
        nop(0,            1'b0, 1, 0, 2);

        // ---------------- deep build: 3 stages, load latency 2, 3-bit count ----------------
        cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Dependent right behind the load: 2 stalls, then stage 3.
        lw(1, 2, 1,       1'b0, 0, 0, 0);
        alu(1, 6, 2, 7,   1'b1, 0, 0, 0);
        alu(1, 6, 2, 7,   1'b1, 0, 0, 1);
        alu(1, 6, 2, 7,   1'b0, 0, 0, 2);
        nop(1,            1'b0, 3, 0, 2);

        // One independent instruction in between: 1 stall.
        lw(1, 2, 1,       1'b0, 0, 0, 2);
        alu(1, 9, 1, 1,   1'b0, 0, 0, 2);
        alu(1, 6, 2, 7,   1'b1, 0, 0, 2);
        alu(1, 6, 2, 7,   1'b0, 0, 0, 3);
        nop(1,            1'b0, 3, 0, 3);

        // Six more stall cycles (9 total): counter saturates at 7.
        n = 3;
        for (int i = 0; i < 3; i++) begin
            lw(1, 2, 1,       1'b0, 0, 0, (n > 7) ? 7 : n);
            alu(1, 6, 2, 7,   1'b1, 0, 0, (n > 7) ? 7 : n);
            n++;
            alu(1, 6, 2, 7,   1'b1, 0, 0, (n > 7) ? 7 : n);
            n++;
            alu(1, 6, 2, 7,   1'b0, 0, 0, (n > 7) ? 7 : n);
            nop(1,            1'b0, 3, 0, (n > 7) ? 7 : n);
        end

        // Reset in the middle of a stall discards every in-flight tag.
        lw(1, 2, 1,       1'b0, 0, 0, 7);
        alu(1, 6, 2, 7,   1'b1, 0, 0, 7);
        cyc(1, 1'b1, 1'b0, 1'b0, 1'b1, 6, 2, 7, 1'b1, 1'b0, 1'b1, 0, 0, 7);
        alu(1, 6, 2, 7,   1'b0, 0, 0, 0);
        nop(1,            1'b0, 0, 0, 0);

        @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard_unit.md
Name: fwd_scoreboard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined MIPS core; the successor to the fixed 2-source, 2-stage combinational forwarding logic.
- Keeps its own shadow pipeline of destination tags from EX through FWD_STAGES post-EX stages.
- Produces per-operand forwarding selects for the EX-stage instruction, a load-use stall request for ID, and a saturating stall-cycle counter.
- Sits beside the ID/EX pipeline register and is driven by ID-stage decode.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands per instruction.
- FWD_STAGES, 2, number of post-EX stages that can forward (stage 1 = EX/MEM, stage 2 = MEM/WB, ...). Must be at least 1.
- LOAD_LAT, 1, stages after EX/MEM before a load result can be forwarded. Legal range 0..FWD_STAGES-1.
- CNT_W, 16, stall counter width.
- SEL_W = clog2(FWD_STAGES+1). Derived, not overridable.

Ports:
- clk  in  1  clock. One clock domain; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- hold  in  1  global pipeline freeze, e.g. a memory wait.
- flush  in  1  kills the ID-stage instruction, e.g. taken branch or jump.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_SRC*REG_AW  ID source registers; source s occupies bits [s*REG_AW +: REG_AW].
- id_use  in  NUM_SRC  per-source "operand actually read".
- id_rd  in  REG_AW  ID destination register.
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- stall  out  1  hold PC and IF/ID, and insert a bubble into EX.
- fwd_sel  out  NUM_SRC*SEL_W  per EX operand: 0 = register file, k = forward from stage k.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State:
  - EX slot: {v, rd, wr, ld, rs[NUM_SRC], use[NUM_SRC]}.
  - Tag pipe p[1..FWD_STAGES]: {v, rd, wr, ld}.
  - stall_count.
- Reset:
  - All v=0 and stall_count=0.
  - Outputs reset to stall=0 and fwd_sel=0.
  - Reset asserted mid-operation discards all in-flight tags on that edge.
- A "producer" is an entry with v & wr & rd!=0. Register 0 never matches.
- Edge update when hold=0 and reset=0:
  - p[k] <= p[k-1] for k=2..FWD_STAGES.
  - p[1] <= EX slot tag.
  - EX slot <= bubble (v=0) if flush or stall; otherwise the ID fields with v=id_valid.
- hold=1: all state frozen, including stall_count. hold has no effect while reset=1.
- fwd_sel[s]:
  - Equals the smallest k with p[k] a producer, p[k].rd==EX.rs[s], EX.use[s]=1 and EX.v=1. Otherwise 0.
  - Youngest producer wins.
  - Purely a function of registered state, so it is glitch-free within the cycle.
- stall (combinational):
  - For each s with id_use[s] and id_rs[s]!=0: find the youngest producer matching id_rs[s], where j=0 is the EX slot and j>=1 is p[j].
  - That source is hazardous if the producer is a load (ld=1) and j < LOAD_LAT + 0 (i.e. j < LOAD_LAT) at j=0 counts as: the producer reaches stage j+1 when ID enters EX, so hazard when j+1 < 1+LOAD_LAT.
  - stall = id_valid & ~flush & OR(hazardous sources).
  - An older load shadowed by a younger ALU producer of the same register does not stall.
  - LOAD_LAT=0 never stalls.
- Multi-cycle stalls:
  - With LOAD_LAT=L, a dependent instruction stalls exactly L-j cycles.
  - A bubble enters EX each stalled cycle while the load advances through the tag pipe.
- stall_count:
  - Increments on each edge where stall=1, hold=0 and reset=0.
  - Saturates at all-ones; no wrap.
- flush together with stall: flush wins. The bubble enters EX, stall=0, no count.
- Invariant checked in bench: fwd_sel never selects a stage k where p[k].ld=1 and k<1+LOAD_LAT.

Test Plan:
1. Defaults; issue add $3 then sub $5,$3,$4 back-to-back -> next cycle fwd_sel[0]=1, fwd_sel[1]=0; one cycle later with an unrelated instruction in EX, a $3 reader gets sel=2.
2. $3 written by the instruction in stage 1 and by the one in stage 2, EX reads $3 -> sel=1, not 2. Destination $0 written, EX reads $0 -> sel=0.
3. Defaults; lw $2 followed immediately by add $6,$2,$7 -> stall=1 for exactly 1 cycle and the EX slot is a bubble; then add enters EX with fwd_sel[0]=2; stall_count=1.
4. FWD_STAGES=3, LOAD_LAT=2; lw $2 then a dependent instruction -> stall 2 cycles, then sel=3. With one independent instruction in between -> stall 1 cycle.
5. Stall condition present with flush=1 -> stall=0, bubble enters EX, stall_count unchanged. Stall with hold=1 for 4 cycles -> state frozen and the count does not advance.
6. CNT_W=3 with 9 stall cycles -> stall_count=7. Assert reset mid-stall -> next cycle all fwd_sel=0, stall=0, count=0.
